// File: rtl/stream_arb_pkg.sv
// Shared types and helpers for the round-robin stream arbiter.
// Packet locking is enabled by defining STREAM_ARB_LOCK_EN.
package stream_arb_pkg;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    function automatic int id_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority search: first set request at or after ptr, wrapping.
// Purely combinational.
module rr_pick
    import stream_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IW    = id_w(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic             found,
    output logic [IW-1:0]    idx
);

    int k;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        k     = 0;
        for (int i = 0; i < N_REQ; i++) begin
            k = int'(ptr) + i;
            if (k >= N_REQ) k = k - N_REQ;
            if (!found && req[k[IW-1:0]]) begin
                found = 1'b1;
                idx   = k[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/stream_rr_arb.sv
// N-way round-robin stream arbiter with a one-entry output register.
// Define STREAM_ARB_LOCK_EN to hold the grant for a whole packet.
module stream_rr_arb
    import stream_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       i_vld,
    output logic [N_REQ-1:0]       i_rdy,
    input  logic [N_REQ*WIDTH-1:0] i_data,
    input  logic [N_REQ-1:0]       i_last,
    output logic                   o_vld,
    input  logic                   o_rdy,
    output logic [WIDTH-1:0]       o_data,
    output logic                   o_last,
    output logic [$clog2(N_REQ)-1:0] o_id
);

    localparam int IW = id_w(N_REQ);

    logic             full;
    logic             slot_free;
    logic [IW-1:0]    ptr;
    logic [IW-1:0]    ptr_nxt;
    logic             pick_vld;
    logic [IW-1:0]    pick;
    logic             sel_vld;
    logic [IW-1:0]    sel;
    logic [IW-1:0]    sel_inc;
    logic             accept;
    logic             beat_last;
    logic [WIDTH-1:0] beat_data;

    assign slot_free = !full || o_rdy;
    assign o_vld     = full;

    rr_pick #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_pick (
        .req   (i_vld),
        .ptr   (ptr),
        .found (pick_vld),
        .idx   (pick)
    );

`ifdef STREAM_ARB_LOCK_EN
    arb_state_e    state;
    arb_state_e    state_nxt;
    logic [IW-1:0] gnt;
    logic [IW-1:0] gnt_nxt;

    assign sel_vld = (state == ARB_LOCKED) ? 1'b1 : pick_vld;
    assign sel     = (state == ARB_LOCKED) ? gnt : pick;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ARB_IDLE;
            gnt   <= '0;
            ptr   <= '0;
        end else begin
            state <= state_nxt;
            gnt   <= gnt_nxt;
            ptr   <= ptr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt;
        ptr_nxt   = ptr;
        unique case (state)
            ARB_IDLE: begin
                if (accept) begin
                    if (beat_last) begin
                        ptr_nxt = sel_inc;
                    end else begin
                        state_nxt = ARB_LOCKED;
                        gnt_nxt   = pick;
                    end
                end
            end
            ARB_LOCKED: begin
                // Stays here until the granted source ends its packet.
                if (accept && beat_last) begin
                    state_nxt = ARB_IDLE;
                    ptr_nxt   = sel_inc;
                end
            end
        endcase
    end
`else
    assign sel_vld = pick_vld;
    assign sel     = pick;
    assign ptr_nxt = accept ? sel_inc : ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr <= '0;
        else        ptr <= ptr_nxt;
    end
`endif

    // Ready is forced low while reset is held.
    always_comb begin
        i_rdy = '0;
        if (rst_n && sel_vld) i_rdy[sel] = slot_free;
    end

    assign sel_inc   = (sel == IW'(N_REQ - 1)) ? '0 : sel + 1'b1;
    assign accept    = |(i_vld & i_rdy);
    assign beat_last = i_last[sel];
    assign beat_data = i_data[sel*WIDTH +: WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full   <= 1'b0;
            o_last <= 1'b0;
            o_id   <= '0;
        end else if (accept) begin
            full   <= 1'b1;
            o_last <= beat_last;
            o_id   <= sel;
        end else if (o_rdy) begin
            full   <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) o_data <= beat_data;
    end

endmodule

// File: tb/tb_stream_rr_arb.sv
// Scoreboard bench for stream_rr_arb against a queue-based arbitration model.
// Lock-specific expectations apply when STREAM_ARB_LOCK_EN is defined.
module tb_stream_rr_arb;

    localparam int N = 4;
    localparam int W = 32;

    typedef struct {
        logic [W-1:0] d;
        logic         l;
        logic [1:0]   id;
    } beat_t;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   i_vld;
    logic [N-1:0]   i_rdy;
    logic [N*W-1:0] i_data;
    logic [N-1:0]   i_last;
    logic           o_vld;
    logic           o_rdy;
    logic [W-1:0]   o_data;
    logic           o_last;
    logic [1:0]     o_id;

    stream_rr_arb #(.N_REQ(N), .WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_vld  (i_vld),
        .i_rdy  (i_rdy),
        .i_data (i_data),
        .i_last (i_last),
        .o_vld  (o_vld),
        .o_rdy  (o_rdy),
        .o_data (o_data),
        .o_last (o_last),
        .o_id   (o_id)
    );

    always #5 clk = ~clk;

    int           n_vec = 0;
    int           n_err = 0;
    beat_t        q[$];
    logic         m_full;
    int           m_ptr;
    bit           m_locked;
    int           m_gnt;
    int           acc_k;
    logic [W-1:0] src_data [N];
    bit           pend [N];
    logic [N-1:0] pend_last;

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    task automatic model_flush();
        q.delete();
        m_full   = 1'b0;
        m_ptr    = 0;
        m_locked = 1'b0;
        m_gnt    = 0;
    endtask

    // Model: decide which requester the spec allows this cycle.
    task automatic evaluate();
        logic [N-1:0] exp_rdy;
        bit           slot_free;
        int           pick;
        int           k;
        beat_t        b;
        slot_free = !m_full || o_rdy;
        exp_rdy   = '0;
        pick      = -1;
        for (int i = 0; i < N; i++) begin
            if (pick < 0 && i_vld[(m_ptr + i) % N]) pick = (m_ptr + i) % N;
        end
        if (m_locked) k = m_gnt;
        else          k = pick;
        if (k >= 0) exp_rdy[k] = slot_free;
        chk("i_rdy", 64'(i_rdy), 64'(exp_rdy));
        acc_k = -1;
        if (k >= 0 && slot_free && i_vld[k]) begin
            acc_k = k;
            b.d  = src_data[k];
            b.l  = i_last[k];
            b.id = 2'(k);
            q.push_back(b);
`ifdef STREAM_ARB_LOCK_EN
            if (m_locked) begin
                if (i_last[k]) begin
                    m_locked = 1'b0;
                    m_ptr    = (k + 1) % N;
                end
            end else if (i_last[k]) begin
                m_ptr = (k + 1) % N;
            end else begin
                m_locked = 1'b1;
                m_gnt    = k;
            end
`else
            m_ptr = (k + 1) % N;
`endif
        end
        m_full = (acc_k >= 0) ? 1'b1 : (o_rdy ? 1'b0 : m_full);
    endtask

    task automatic tick(input logic [N-1:0] v, input logic [N-1:0] l,
                        input logic r);
        @(negedge clk);
        i_vld = v;
        i_last = l;
        o_rdy = r;
        for (int k = 0; k < N; k++) i_data[k*W +: W] = src_data[k];
        #4;
        evaluate();
    endtask

    task automatic dtick(input logic [N-1:0] v, input logic [N-1:0] l,
                         input logic r);
        for (int k = 0; k < N; k++) src_data[k] = $urandom;
        tick(v, l, r);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_o_vld", 64'(o_vld), 64'd0);
        chk("rst_i_rdy", 64'(i_rdy), 64'd0);
        chk("rst_o_last", 64'(o_last), 64'd0);
        chk("rst_o_id", 64'(o_id), 64'd0);
        model_flush();
        i_vld = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: compares the output register with the scoreboard head.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst_n) begin
                chk("o_vld", 64'(o_vld), 64'(m_full));
                if (o_vld) begin
                    if (q.size() == 0) begin
                        chk("unexpected_beat", 64'(q.size()), 64'd1);
                    end else begin
                        chk("o_data", 64'(o_data), 64'(q[0].d));
                        chk("o_last", 64'(o_last), 64'(q[0].l));
                        chk("o_id", 64'(o_id), 64'(q[0].id));
                        if (o_rdy) void'(q.pop_front());
                    end
                end
            end
        end
    end

    int exp1 [5] = '{0, 1, 2, 3, 0};

    initial begin
        rst_n  = 1'b0;
        i_vld  = '0;
        i_last = '0;
        i_data = '0;
        o_rdy  = 1'b0;
        model_flush();
        for (int k = 0; k < N; k++) begin
            src_data[k] = '0;
            pend[k]     = 1'b0;
        end
        pend_last = '0;
        #1;
        chk("init_o_vld", 64'(o_vld), 64'd0);
        chk("init_i_rdy", 64'(i_rdy), 64'd0);
        do_reset();

        // Back-to-back single-beat packets from all requesters.
        for (int i = 0; i < 5; i++) begin
            dtick(4'b1111, 4'b1111, 1'b1);
            chk("rr_seq", 64'(acc_k), 64'(exp1[i]));
        end
        dtick(4'b0000, 4'b0000, 1'b1);
        dtick(4'b0000, 4'b0000, 1'b1);

        // Wrap from the top requester back to 0.
        do_reset();
        dtick(4'b1000, 4'b1000, 1'b1);
        chk("wrap_gnt3", 64'(acc_k), 64'd3);
        dtick(4'b1001, 4'b1001, 1'b1);
        chk("wrap_gnt0", 64'(acc_k), 64'd0);

        // Output stall with a buffered beat.
        dtick(4'b0001, 4'b0001, 1'b1);
        chk("stall_load", 64'(acc_k), 64'd0);
        for (int i = 0; i < 5; i++) begin
            tick(4'b0010, 4'b0010, 1'b0);
            chk("stall_noacc", 64'(acc_k), 64'hffff_ffff_ffff_ffff);
        end
        dtick(4'b0000, 4'b0000, 1'b1);
        dtick(4'b0000, 4'b0000, 1'b1);

        // Three-beat packet from req1 with req2 waiting.
        do_reset();
        dtick(4'b0110, 4'b0000, 1'b1);
        chk("pkt_b1", 64'(acc_k), 64'd1);
        dtick(4'b0110, 4'b0000, 1'b1);
`ifdef STREAM_ARB_LOCK_EN
        chk("pkt_b2", 64'(acc_k), 64'd1);
`endif
        dtick(4'b0110, 4'b0010, 1'b1);
`ifdef STREAM_ARB_LOCK_EN
        chk("pkt_b3", 64'(acc_k), 64'd1);
`endif
        dtick(4'b0100, 4'b0100, 1'b1);
        chk("pkt_next", 64'(acc_k), 64'd2);
        dtick(4'b0000, 4'b0000, 1'b1);

        // Reset mid-packet on req2.
        do_reset();
        dtick(4'b0100, 4'b0000, 1'b1);
        chk("mid_start", 64'(acc_k), 64'd2);
        do_reset();
        dtick(4'b0101, 4'b0101, 1'b1);
        chk("post_rst_gnt", 64'(acc_k), 64'd0);
        dtick(4'b0000, 4'b0000, 1'b1);

        // Random soak with stalls and sparse valids.
        for (int c = 0; c < 10000; c++) begin
            logic [N-1:0] v;
            for (int k = 0; k < N; k++) begin
                if (!pend[k] && ($urandom % 3) == 0) begin
                    pend[k]      = 1'b1;
                    src_data[k]  = $urandom;
                    pend_last[k] = (($urandom % 3) == 0);
                end
                v[k] = pend[k];
            end
            tick(v, pend_last, (($urandom % 4) != 0));
            if (acc_k >= 0) pend[acc_k] = 1'b0;
        end

        for (int i = 0; i < 20; i++) begin
            if (q.size() != 0) dtick(4'b0000, 4'b0000, 1'b1);
        end
        chk("drain_empty", 64'(q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
